// File: rtl/multicycle_alu_pkg.sv
// Shared definitions for the execution-stage ALU: op codes (also used by the
// ALU control decoder) and FSM state encodings.
`timescale 1ns/1ps
package multicycle_alu_pkg;

  localparam logic [3:0] ALU_AND     = 4'b0000;
  localparam logic [3:0] ALU_OR      = 4'b0001;
  localparam logic [3:0] ALU_NOR     = 4'b0010;
  localparam logic [3:0] ALU_ADD     = 4'b0011;
  localparam logic [3:0] ALU_SUB     = 4'b0100;
  localparam logic [3:0] ALU_SLL     = 4'b0101;
  localparam logic [3:0] ALU_SRL     = 4'b0110;
  localparam logic [3:0] ALU_LUI     = 4'b0111;
  localparam logic [3:0] ALU_INVALID = 4'b1001;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_DONE  = 2'd2
  } state_t;

  // Every code with the top bit set is outside the supported set.
  function automatic logic op_is_valid(input logic [3:0] op);
    return ~op[3];
  endfunction

endpackage

// File: rtl/alu_serial_shifter.sv
// Iterative one-bit-per-step shifter: accumulator, down-counter and direction,
// loaded at the accepting edge and stepped once per SHIFT cycle.
`timescale 1ns/1ps
module alu_serial_shifter #(
  parameter int DATA_WIDTH  = 32,
  parameter int SHAMT_WIDTH = 5
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   load,
  input  logic                   step,
  input  logic                   load_left,
  input  logic [DATA_WIDTH-1:0]  load_value,
  input  logic [SHAMT_WIDTH-1:0] load_count,
  output logic [DATA_WIDTH-1:0]  acc_stepped,
  output logic                   last_step
);

  logic [DATA_WIDTH-1:0]  acc_reg;
  logic [SHAMT_WIDTH-1:0] count_reg;
  logic                   left_reg;
  logic [DATA_WIDTH-1:0]  left_bits;
  logic [DATA_WIDTH-1:0]  right_bits;

  // One-position shift in each direction, zero filled.
  for (genvar gi = 0; gi < DATA_WIDTH; gi++) begin : g_bit
    if (gi == 0) begin : g_lsb
      assign left_bits[gi] = 1'b0;
    end else begin : g_lmid
      assign left_bits[gi] = acc_reg[gi-1];
    end
    if (gi == DATA_WIDTH - 1) begin : g_msb
      assign right_bits[gi] = 1'b0;
    end else begin : g_rmid
      assign right_bits[gi] = acc_reg[gi+1];
    end
  end

  assign acc_stepped = left_reg ? left_bits : right_bits;
  assign last_step   = (count_reg == SHAMT_WIDTH'(1));

  always_ff @(posedge clk) begin
    if (reset) begin
      acc_reg   <= '0;
      count_reg <= '0;
      left_reg  <= 1'b0;
    end else if (load) begin
      acc_reg   <= load_value;
      count_reg <= load_count;
      left_reg  <= load_left;
    end else if (step) begin
      acc_reg   <= acc_stepped;
      count_reg <= count_reg - SHAMT_WIDTH'(1);
    end
  end

endmodule

// File: rtl/multicycle_alu.sv
// Execution-stage ALU: single-cycle logic/arith/LUI, iterative SLL/SRL, with a
// start/busy/done handshake for the multicycle control FSM.
`timescale 1ns/1ps
module multicycle_alu
  import multicycle_alu_pkg::*;
#(
  parameter int DATA_WIDTH  = 32,
  parameter int SHAMT_WIDTH = 5
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   start,
  input  logic [3:0]             ALUOperation,
  input  logic [DATA_WIDTH-1:0]  A,
  input  logic [DATA_WIDTH-1:0]  B,
  input  logic [SHAMT_WIDTH-1:0] shamt,
  output logic                   busy,
  output logic                   done,
  output logic [DATA_WIDTH-1:0]  ALUResult,
  output logic                   Zero,
  output logic                   op_error
);

  state_t                state_reg, state_next;
  logic [DATA_WIDTH-1:0] result_reg, result_next, single_result, acc_stepped;
  logic                  zero_reg, err_reg, err_next, write_result;
  logic                  accept, is_shift, long_shift, op_valid;
  logic                  shift_load, shift_step, last_step;

  assign accept     = (state_reg == S_IDLE) && start;
  assign is_shift   = (ALUOperation == ALU_SLL) || (ALUOperation == ALU_SRL);
  assign long_shift = is_shift && (shamt != '0);
  assign op_valid   = op_is_valid(ALUOperation);

  always_comb begin
    single_result = '0;
    case (ALUOperation)
      ALU_AND:          single_result = A & B;
      ALU_OR:           single_result = A | B;
      ALU_NOR:          single_result = ~(A | B);
      ALU_ADD:          single_result = A + B;
      ALU_SUB:          single_result = A - B;
      ALU_SLL, ALU_SRL: single_result = B;  // only reached with shamt == 0
      ALU_LUI:          single_result = B << 16;
      default:          single_result = '0;
    endcase
  end

  alu_serial_shifter #(
    .DATA_WIDTH (DATA_WIDTH),
    .SHAMT_WIDTH(SHAMT_WIDTH)
  ) u_shifter (
    .clk        (clk),
    .reset      (reset),
    .load       (shift_load),
    .step       (shift_step),
    .load_left  (ALUOperation == ALU_SLL),
    .load_value (B),
    .load_count (shamt),
    .acc_stepped(acc_stepped),
    .last_step  (last_step)
  );

  always_comb begin
    state_next = state_reg;
    shift_load = 1'b0;
    shift_step = 1'b0;
    case (state_reg)
      S_IDLE: begin
        if (start) begin
          if (long_shift) begin
            state_next = S_SHIFT;
            shift_load = 1'b1;
          end else begin
            state_next = S_DONE;
          end
        end
      end
      S_SHIFT: begin
        shift_step = 1'b1;
        if (last_step) state_next = S_DONE;
      end
      S_DONE:  state_next = S_IDLE;
      default: state_next = S_IDLE;
    endcase
  end

  // The visible result changes only on the way into DONE; the final shift
  // step is folded into that write.
  always_comb begin
    write_result = 1'b0;
    result_next  = '0;
    err_next     = 1'b0;
    if (accept && !long_shift) begin
      write_result = 1'b1;
      result_next  = op_valid ? single_result : '0;
      err_next     = ~op_valid;
    end else if ((state_reg == S_SHIFT) && last_step) begin
      write_result = 1'b1;
      result_next  = acc_stepped;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg  <= S_IDLE;
      result_reg <= '0;
      zero_reg   <= 1'b1;
      err_reg    <= 1'b0;
    end else begin
      state_reg <= state_next;
      if (write_result) begin
        result_reg <= result_next;
        zero_reg   <= (result_next == '0);
        err_reg    <= err_next;
      end
    end
  end

  assign busy      = (state_reg != S_IDLE);
  assign done      = (state_reg == S_DONE);
  assign ALUResult = result_reg;
  assign Zero      = zero_reg;
  assign op_error  = err_reg;

endmodule
